demux_rr: RTL and testbench
===========================

Name: demux_rr

Overview:
- Parametrised 1:N round-robin byte demultiplexer; successor to the 1:2 phy demux.
- Sits in the phy receive path after the unstriping stage.
- Distributes a valid-qualified input stream across NUM_LANES output lanes in round-robin order, skipping disabled lanes.
- Resynchronises its lane pointer to the lowest enabled lane after an idle gap; flags words that cannot be placed.

Parameters:
- DATA_W, 8, width of the data word.
- NUM_LANES, 4, number of output lanes (legal range 2..8).
- PTR_W, $clog2(NUM_LANES), lane pointer width (derived, not overridden).
- RESYNC_ON_IDLE, 1, 1 = pointer returns to lowest enabled lane after an idle gap; 0 = pointer holds.
- IDLE_CYC, 2, consecutive invalid cycles that trigger resync (legal range 1..15).

Ports:
- clk_2f  in  1  block clock
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_W  input word
- valid_in  in  1  data_in is valid this cycle
- lane_en  in  NUM_LANES  per-lane enable; bit i enables lane i
- data_out  out  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- valid_out  out  NUM_LANES  one-hot or zero; lane i is valid this cycle
- lane_ptr  out  PTR_W  lane that the next valid word will target
- drop_err  out  1  one-cycle pulse: a valid word was dropped
- word_cnt  out  16  count of words placed, wrapping

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, sampled on posedge clk_2f.
  - On reset, all outputs clear: data_out=0, valid_out=0, lane_ptr=0, drop_err=0, word_cnt=0. The idle counter also clears.
  - Reset asserted mid-stream discards the in-flight word; its valid_out is never asserted.
- Target lane selection (combinational from registered state):
  - tgt = first enabled lane scanning upward from lane_ptr, wrapping modulo NUM_LANES.
  - none = (lane_en == 0).
- Accepted word (valid_in=1 and !none), at the next edge:
  - data_out[tgt] <= data_in and valid_out <= (1<<tgt).
  - lane_ptr <= (tgt+1) mod NUM_LANES.
  - word_cnt increments, wrapping 0xFFFF -> 0.
  - Idle counter clears.
- Latency: exactly 1 cycle, valid_in to valid_out.
- Dropped word (valid_in=1 and none): valid_out <= 0; drop_err <= 1 for one cycle; lane_ptr, word_cnt and data_out hold.
- Invalid cycle (valid_in=0):
  - valid_out <= 0; data_out holds its last values on every lane.
  - Idle counter increments, saturating at IDLE_CYC.
  - When RESYNC_ON_IDLE=1 and the counter reaches IDLE_CYC, lane_ptr <= lowest enabled lane, or 0 if none.
- Idle counter state machine:
  - Two states: ACTIVE and IDLE.
  - ACTIVE -> IDLE when the counter reaches IDLE_CYC.
  - IDLE -> ACTIVE on the first accepted word.
  - Resync fires once, on entry to IDLE.
- lane_en changes take effect in the same cycle they are applied; there is no pipelining of the mask.
  - A disabled lane keeps its last data_out; its valid_out stays 0.
- Non-target lanes never toggle data_out; this is the power/glitch rule.
- Any word that lands on a lane sets exactly one bit of valid_out.

Decomposition:
- Package phy_pkg holds:
  - the lane-index function first_enabled(mask, start), returning index plus found flag;
  - the constant CNT_W=16;
  - the lane-slice macro/function for the packed data_out.
- One sub-module is natural: lane_arbiter_rr, the combinational find-first-enabled-from-pointer with wrap. It is reusable by the matching mux.
- Registers stay in demux_rr.

Test Plan:
- Round robin: reset, lane_en=4'b1111, valid_in=1 for words 0xA0..0xA5 -> lanes 0,1,2,3,0,1 valid on consecutive cycles at 1-cycle latency; word_cnt=6; lane_ptr=2.
- Lane skipping: lane_en=4'b1010, words 0x11,0x22,0x33 -> lanes 1,3,1; lanes 0 and 2 never valid and their data_out unchanged.
- Idle resync: with RESYNC_ON_IDLE=1, IDLE_CYC=2, send 0x01 to lane 0, then valid_in=0 for 2 cycles -> lane_ptr=0. Next word 0x02 -> lane 0. A 1-cycle gap instead -> 0x02 lands on lane 1.
- Drop: lane_en=0, valid_in=1 with 0x55 -> drop_err pulses 1 cycle, valid_out=0, word_cnt unchanged. Then re-enable lane_en=4'b0100 and send 0x66 -> lane 2.
- Mid-stream reset: streaming 0xC0.. with reset asserted 1 cycle -> next edge all outputs 0, lane_ptr=0, no valid_out for the interrupted word. The first post-reset word goes to lane 0.
- Counter wrap: force 65536 accepted words -> word_cnt returns to 0x0000 with no other side effect.

Source files
------------

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared lane-selection helpers and constants for the phy demux/mux pair
package phy_pkg;

    localparam int CNT_W      = 16;
    localparam int MAX_LANES  = 8;
    localparam int LANE_IDX_W = 3;

    typedef struct packed {
        logic [LANE_IDX_W-1:0] idx;
        logic                  found;
    } lane_sel_t;

    // Scan downward so the lowest offset from start is the one left standing.
    function automatic lane_sel_t first_enabled(input logic [MAX_LANES-1:0]  mask,
                                                input logic [LANE_IDX_W-1:0] start,
                                                input int                    num_lanes);
        lane_sel_t             sel;
        logic [LANE_IDX_W-1:0] lane;
        sel.idx   = '0;
        sel.found = 1'b0;
        for (int k = MAX_LANES - 1; k >= 0; k--) begin
            if (k < num_lanes) begin
                lane = LANE_IDX_W'((int'(start) + k) % num_lanes);
                if (mask[lane]) begin
                    sel.idx   = lane;
                    sel.found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    function automatic int lane_lo(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/lane_arbiter_rr.sv
// rtl/lane_arbiter_rr.sv - first enabled lane at or above a pointer, wrapping
module lane_arbiter_rr
    import phy_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic [PTR_W-1:0]     ptr,
    output logic [PTR_W-1:0]     tgt,
    output logic                 none
);

    lane_sel_t sel;

    always_comb begin
        sel  = first_enabled(MAX_LANES'(lane_en), LANE_IDX_W'(ptr), NUM_LANES);
        tgt  = PTR_W'(sel.idx);
        none = (lane_en == '0);
    end

endmodule

// File: rtl/demux_rr.sv
// rtl/demux_rr.sv - 1:N round-robin byte demultiplexer with idle resync and drop flag
module demux_rr
    import phy_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_LANES      = 4,
    parameter int PTR_W          = $clog2(NUM_LANES),
    parameter int RESYNC_ON_IDLE = 1,
    parameter int IDLE_CYC       = 2
) (
    input  logic                        clk_2f,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid_in,
    input  logic [NUM_LANES-1:0]        lane_en,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic [NUM_LANES-1:0]        valid_out,
    output logic [PTR_W-1:0]            lane_ptr,
    output logic                        drop_err,
    output logic [CNT_W-1:0]            word_cnt
);

    typedef enum logic {ACTIVE, IDLE} idle_state_t;

    localparam logic [3:0]       IDLE_MAX  = 4'(IDLE_CYC);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    idle_state_t      state;
    logic [3:0]       idle_cnt;
    logic [PTR_W-1:0] tgt;
    logic [PTR_W-1:0] low_lane;
    logic             none;
    logic             unused_low_none;

    lane_arbiter_rr #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_arb (
        .lane_en (lane_en),
        .ptr     (lane_ptr),
        .tgt     (tgt),
        .none    (none)
    );

    // Pointer fixed at zero yields the lowest enabled lane (0 when none enabled).
    lane_arbiter_rr #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_low (
        .lane_en (lane_en),
        .ptr     ('0),
        .tgt     (low_lane),
        .none    (unused_low_none)
    );

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= '0;
            lane_ptr  <= '0;
            drop_err  <= 1'b0;
            word_cnt  <= '0;
            idle_cnt  <= '0;
            state     <= ACTIVE;
        end else begin
            valid_out <= '0;
            drop_err  <= 1'b0;
            if (valid_in) begin
                if (!none) begin
                    data_out[lane_lo(int'(tgt), DATA_W) +: DATA_W] <= data_in;
                    valid_out <= NUM_LANES'(1) << tgt;
                    lane_ptr  <= (tgt == LAST_LANE) ? '0 : tgt + 1'b1;
                    word_cnt  <= word_cnt + 1'b1;
                    idle_cnt  <= '0;
                    state     <= ACTIVE;
                end else begin
                    drop_err <= 1'b1;
                end
            end else begin
                if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 4'd1;
                end
                // Resync only on the transition into IDLE, never again while idle.
                if (state == ACTIVE && idle_cnt == IDLE_MAX - 4'd1) begin
                    state <= IDLE;
                    if (RESYNC_ON_IDLE != 0) begin
                        lane_ptr <= low_lane;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_rr.sv
// tb/tb_demux_rr.sv - scoreboard bench for demux_rr
module tb_demux_rr;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int IDLE_CYC = 2;

    logic           clk_2f;
    logic           reset;
    logic [W-1:0]   data_in;
    logic           valid_in;
    logic [N-1:0]   lane_en;
    logic [N*W-1:0] data_out;
    logic [N-1:0]   valid_out;
    logic [1:0]     lane_ptr;
    logic           drop_err;
    logic [15:0]    word_cnt;

    demux_rr #(
        .DATA_W(W), .NUM_LANES(N), .RESYNC_ON_IDLE(1), .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .lane_en   (lane_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_ptr  (lane_ptr),
        .drop_err  (drop_err),
        .word_cnt  (word_cnt)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic [N*W-1:0] data;
        logic [N-1:0]   valid;
        logic [1:0]     ptr;
        logic           drop;
        logic [15:0]    cnt;
    } exp_t;

    exp_t     sb_q[$];
    exp_t     mon_e;
    int       n_tests = 0;
    int       n_fail  = 0;

    int       m_ptr, m_cnt, m_idle;
    bit       m_in_idle;
    logic [W-1:0] m_data [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic [N-1:0] en);
        exp_t       e;
        int         tgt;
        logic [1:0] j;
        reset    = r;
        valid_in = v;
        data_in  = d;
        lane_en  = en;
        e.valid  = '0;
        e.drop   = 1'b0;
        if (r) begin
            m_ptr = 0; m_cnt = 0; m_idle = 0; m_in_idle = 0;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else if (v) begin
            tgt = -1;
            for (int k = 0; k < N; k++) begin
                j = 2'((m_ptr + k) % N);
                if (tgt < 0 && en[j]) tgt = int'(j);
            end
            if (tgt >= 0) begin
                m_data[tgt] = d;
                e.valid     = N'(1) << tgt;
                m_ptr       = (tgt + 1) % N;
                m_cnt       = (m_cnt + 1) % 65536;
                m_idle      = 0;
                m_in_idle   = 0;
            end else begin
                e.drop = 1'b1;
            end
        end else begin
            if (m_idle < IDLE_CYC) m_idle++;
            if (!m_in_idle && m_idle == IDLE_CYC) begin
                m_in_idle = 1;
                m_ptr     = 0;
                for (int k = N - 1; k >= 0; k--) if (en[k]) m_ptr = k;
            end
        end
        e.data = {m_data[3], m_data[2], m_data[1], m_data[0]};
        e.ptr  = 2'(m_ptr);
        e.cnt  = 16'(m_cnt);
        sb_q.push_back(e);
        @(posedge clk_2f);
        #1;
    endtask

    always @(negedge clk_2f) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_valid", 64'(valid_out), 64'(mon_e.valid));
            check("sb_data",  64'(data_out),  64'(mon_e.data));
            check("sb_ptr",   64'(lane_ptr),  64'(mon_e.ptr));
            check("sb_drop",  64'(drop_err),  64'(mon_e.drop));
            check("sb_cnt",   64'(word_cnt),  64'(mon_e.cnt));
            check("onehot0",  64'($onehot0(valid_out)), 64'(1));
        end
    end

    initial begin
        logic [N-1:0] exp_v;
        reset = 1'b1; valid_in = 1'b0; data_in = '0; lane_en = '0;

        step(1, 0, 8'h00, 4'hF);
        step(1, 0, 8'h00, 4'hF);
        check("rst_data", 64'(data_out), 64'(0));
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_ptr", 64'(lane_ptr), 64'(0));
        check("rst_cnt", 64'(word_cnt), 64'(0));

        // round robin over all lanes
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'(8'hA0 + i), 4'b1111);
            exp_v = 4'b0001 << (i % 4);
            check("rr_lane", 64'(valid_out), 64'(exp_v));
        end
        check("rr_cnt", 64'(word_cnt), 64'(6));
        check("rr_ptr", 64'(lane_ptr), 64'(2));
        check("rr_last", 64'(data_out[15:8]), 64'(8'hA5));

        // lane skipping
        step(1, 0, 8'h00, 4'b1010);
        step(0, 1, 8'h11, 4'b1010);
        check("skip_l1", 64'(valid_out), 64'(4'b0010));
        step(0, 1, 8'h22, 4'b1010);
        check("skip_l3", 64'(valid_out), 64'(4'b1000));
        step(0, 1, 8'h33, 4'b1010);
        check("skip_l1b", 64'(valid_out), 64'(4'b0010));
        check("skip_l0_hold", 64'(data_out[7:0]), 64'(0));
        check("skip_l2_hold", 64'(data_out[23:16]), 64'(0));

        // idle resync after a 2-cycle gap
        step(0, 0, 8'h00, 4'hF);
        step(0, 0, 8'h00, 4'hF);
        check("idle_pre_ptr", 64'(lane_ptr), 64'(0));
        step(0, 1, 8'h01, 4'hF);
        check("idle_w1", 64'(valid_out), 64'(4'b0001));
        step(0, 0, 8'h00, 4'hF);
        step(0, 0, 8'h00, 4'hF);
        check("idle_resync_ptr", 64'(lane_ptr), 64'(0));
        step(0, 1, 8'h02, 4'hF);
        check("idle_w2_lane", 64'(valid_out), 64'(4'b0001));
        check("idle_w2_data", 64'(data_out[7:0]), 64'(8'h02));

        // a 1-cycle gap must not resync
        step(0, 0, 8'h00, 4'hF);
        step(0, 0, 8'h00, 4'hF);
        step(0, 1, 8'h01, 4'hF);
        step(0, 0, 8'h00, 4'hF);
        check("gap1_ptr", 64'(lane_ptr), 64'(1));
        step(0, 1, 8'h02, 4'hF);
        check("gap1_lane", 64'(valid_out), 64'(4'b0010));
        check("gap1_data", 64'(data_out[15:8]), 64'(8'h02));

        // drop with no lanes enabled, then recover on lane 2
        step(0, 1, 8'h55, 4'b0000);
        check("drop_err", 64'(drop_err), 64'(1));
        check("drop_valid", 64'(valid_out), 64'(0));
        check("drop_cnt", 64'(word_cnt), 64'(7));
        step(0, 1, 8'h66, 4'b0100);
        check("drop_pulse", 64'(drop_err), 64'(0));
        check("recover_lane", 64'(valid_out), 64'(4'b0100));
        check("recover_data", 64'(data_out[23:16]), 64'(8'h66));

        // reset in the middle of a stream
        step(0, 1, 8'hC0, 4'hF);
        step(0, 1, 8'hC1, 4'hF);
        step(1, 1, 8'hC2, 4'hF);
        check("mrst_valid", 64'(valid_out), 64'(0));
        check("mrst_data", 64'(data_out), 64'(0));
        check("mrst_ptr", 64'(lane_ptr), 64'(0));
        check("mrst_cnt", 64'(word_cnt), 64'(0));
        step(0, 1, 8'hC3, 4'hF);
        check("mrst_first", 64'(valid_out), 64'(4'b0001));

        // word counter wrap
        step(1, 0, 8'h00, 4'hF);
        for (int i = 0; i < 65535; i++) step(0, 1, 8'(i), 4'hF);
        check("wrap_ffff", 64'(word_cnt), 64'(16'hFFFF));
        step(0, 1, 8'h5A, 4'hF);
        check("wrap_zero", 64'(word_cnt), 64'(0));
        check("wrap_lane", 64'(valid_out), 64'(4'b1000));
        check("wrap_ptr", 64'(lane_ptr), 64'(0));

        step(0, 0, 8'h00, 4'hF);
        @(negedge clk_2f);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
